ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 129 ++++++++++++
 tb/tb_ctrl_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: five-state instruction sequencer with a latched instruction register and decoded controls.
// Optional CTRL_HS_SYNC_EN adds a 2-flop synchroniser on Handshake.
`default_nettype none

module ctrl_seq #(
  parameter int IW   = 12,
  parameter int DW   = 8,
  parameter int IMMW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] Instruction,
  input  logic          Handshake,
  output logic [DW-1:0] Immediate,
  output logic [1:0]    Stage,
  output logic          PCEn,
  output logic          PCHold,
  output logic          RegWrite,
  output logic          ACCWE,
  output logic          RegAddr,
  output logic          SelImm,
  output logic          SelSW,
  output logic          UseMul,
  output logic          UseACC,
  output logic          SelRegData
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    WAIT   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ir;
  logic [6:0]    w_func;
  logic          w_arg;
  logic          w_hs;

`ifdef CTRL_HS_SYNC_EN
  logic r_hs_meta;
  logic r_hs_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_meta <= 1'b0;
      r_hs_sync <= 1'b0;
    end else begin
      r_hs_meta <= Handshake;
      r_hs_sync <= r_hs_meta;
    end
  end

  assign w_hs = r_hs_sync;
`else
  assign w_hs = Handshake;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_ir <= Instruction;
      end
    end
  end

  assign w_func     = r_ir[IW-1 -: 7];
  assign w_arg      = r_ir[0];
  assign UseACC     = w_func[0];
  assign SelSW      = w_func[1];
  assign SelImm     = w_func[2];
  assign UseMul     = w_func[3];
  assign SelRegData = w_func[6];
  assign RegAddr    = r_ir[0];

  // Immediate is the sign-extended field scaled by two (halfword offset).
  if (DW > IMMW + 1) begin : g_imm_ext
    assign Immediate = {{(DW-IMMW-1){r_ir[IMMW-1]}}, r_ir[IMMW-1:0], 1'b0};
  end else begin : g_imm_exact
    assign Immediate = {r_ir[IMMW-1:0], 1'b0};
  end

  always_comb begin
    w_next   = r_state;
    Stage    = 2'd0;
    PCEn     = 1'b0;
    PCHold   = 1'b0;
    RegWrite = 1'b0;
    ACCWE    = 1'b0;
    case (r_state)
      FETCH: begin
        w_next = DECODE;
      end
      DECODE: begin
        Stage  = 2'd1;
        w_next = EXEC;
      end
      EXEC: begin
        Stage  = 2'd2;
        w_next = (w_func[5] && (w_hs == w_arg)) ? WAIT : WB;
      end
      WAIT: begin
        Stage  = 2'd2;
        PCHold = 1'b1;
        w_next = (w_hs == w_arg) ? WAIT : WB;
      end
      WB: begin
        Stage    = 2'd3;
        PCEn     = 1'b1;
        RegWrite = w_func[4];
        ACCWE    = ~w_func[5] & ~w_func[4];
        w_next   = FETCH;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq (default and wide parameter sets).
`default_nettype none

module tb_ctrl_seq;

  logic        clk;
  logic        reset;
  logic [11:0] instr_n;
  logic [15:0] instr_w;
  logic        hs;

  logic [7:0]  imm_n;
  logic [1:0]  stage_n;
  logic        pcen_n, pchold_n, regwr_n, accwe_n;
  logic        regaddr_n, selimm_n, selsw_n, usemul_n, useacc_n, selrd_n;

  logic [11:0] imm_w;
  logic [1:0]  stage_w;
  logic        pcen_w, pchold_w, regwr_w, accwe_w;
  logic        regaddr_w, selimm_w, selsw_w, usemul_w, useacc_w, selrd_w;

  int checks   = 0;
  int failures = 0;
  int hold_cnt;
  bit seen_wb;

`ifdef CTRL_HS_SYNC_EN
  localparam int EXP_HOLD = 7;
`else
  localparam int EXP_HOLD = 5;
`endif

  ctrl_seq u_dut (
    .clk(clk), .reset(reset), .Instruction(instr_n), .Handshake(hs),
    .Immediate(imm_n), .Stage(stage_n), .PCEn(pcen_n), .PCHold(pchold_n),
    .RegWrite(regwr_n), .ACCWE(accwe_n), .RegAddr(regaddr_n), .SelImm(selimm_n),
    .SelSW(selsw_n), .UseMul(usemul_n), .UseACC(useacc_n), .SelRegData(selrd_n)
  );

  ctrl_seq #(.IW(16), .DW(12), .IMMW(7)) u_wide (
    .clk(clk), .reset(reset), .Instruction(instr_w), .Handshake(hs),
    .Immediate(imm_w), .Stage(stage_w), .PCEn(pcen_w), .PCHold(pchold_w),
    .RegWrite(regwr_w), .ACCWE(accwe_w), .RegAddr(regaddr_w), .SelImm(selimm_w),
    .SelSW(selsw_w), .UseMul(usemul_w), .UseACC(useacc_w), .SelRegData(selrd_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe and decoded control of the narrow instance packed for one compare.
  function automatic logic [31:0] all_n();
    return {4'd0, stage_n, imm_n, pcen_n, pchold_n, regwr_n, accwe_n,
            regaddr_n, selimm_n, selsw_n, usemul_n, useacc_n, selrd_n};
  endfunction

  initial begin
    reset   = 1'b0;
    hs      = 1'b0;
    instr_n = '0;
    instr_w = '0;
    #2 reset = 1'b1;
    #1;
    check("reset_all_zero", all_n(), 32'd0);
    check("reset_wide_imm", {20'd0, imm_w}, 32'd0);
    step();
    step();
    check("reset_held_over_edges", all_n(), 32'd0);

    // ACC instruction: IR = 0000001_10101
    instr_n = 12'b0000001_10101;
    instr_w = 16'b0000100_00_1000001;
    reset   = 1'b0;
    check("fetch_stage", {30'd0, stage_n}, 32'd0);
    step();
    check("decode_stage", {30'd0, stage_n}, 32'd1);
    check("decode_ir_not_yet", {31'd0, useacc_n}, 32'd0);
    step();
    check("exec_stage", {30'd0, stage_n}, 32'd2);
    check("exec_useacc", {31'd0, useacc_n}, 32'd1);
    check("exec_selimm", {31'd0, selimm_n}, 32'd0);
    check("exec_regaddr", {31'd0, regaddr_n}, 32'd1);
    check("exec_imm", {24'd0, imm_n}, 32'hEA);
    check("exec_pcen", {31'd0, pcen_n}, 32'd0);
    check("wide_imm", {20'd0, imm_w}, 32'hF82);
    check("wide_selimm", {31'd0, selimm_w}, 32'd1);
    instr_n = ~instr_n;
    instr_w = ~instr_w;
    step();
    check("wb_stage", {30'd0, stage_n}, 32'd3);
    check("wb_accwe", {31'd0, accwe_n}, 32'd1);
    check("wb_regwrite", {31'd0, regwr_n}, 32'd0);
    check("wb_pcen", {31'd0, pcen_n}, 32'd1);
    check("wb_imm_stable", {24'd0, imm_n}, 32'hEA);
    check("wide_imm_stable", {20'd0, imm_w}, 32'hF82);
    check("wide_selimm_stable", {31'd0, selimm_w}, 32'd1);
    check("wide_wb_accwe", {31'd0, accwe_w}, 32'd1);
    step();
    check("back_to_fetch", {30'd0, stage_n}, 32'd0);
    check("fetch_pcen_low", {31'd0, pcen_n}, 32'd0);

    // Register-write instruction: func = 0010000
    instr_n = {7'b0010000, 5'b00000};
    instr_w = 16'b0000100_00_1000001;
    step();
    step();
    check("rw_exec_regwrite", {31'd0, regwr_n}, 32'd0);
    check("rw_exec_accwe", {31'd0, accwe_n}, 32'd0);
    step();
    check("rw_wb_stage", {30'd0, stage_n}, 32'd3);
    check("rw_wb_regwrite", {31'd0, regwr_n}, 32'd1);
    check("rw_wb_accwe", {31'd0, accwe_n}, 32'd0);
    step();
    check("rw_fetch_after_4", {30'd0, stage_n}, 32'd0);
    check("rw_fetch_regwrite", {31'd0, regwr_n}, 32'd0);

    // Wait instruction: func[5]=1, arg=1, Handshake held high then dropped
    instr_n = {7'b0100000, 5'b00001};
    hs      = 1'b1;
    step();
    step();
    check("wt_exec_stage", {30'd0, stage_n}, 32'd2);
    check("wt_exec_pchold", {31'd0, pchold_n}, 32'd0);
    hold_cnt = 0;
    seen_wb  = 1'b0;
    for (int i = 0; i < 20 && !seen_wb; i++) begin
      step();
      if (stage_n == 2'd3) begin
        seen_wb = 1'b1;
      end else begin
        if (pchold_n) hold_cnt++;
        if (hold_cnt == 5) hs = 1'b0;
      end
    end
    check("wt_reached_wb", {31'd0, seen_wb}, 32'd1);
    check("wt_hold_cycles", hold_cnt, EXP_HOLD);
    check("wt_wb_pcen", {31'd0, pcen_n}, 32'd1);
    check("wt_wb_accwe", {31'd0, accwe_n}, 32'd0);
    check("wt_wb_pchold", {31'd0, pchold_n}, 32'd0);
    step();

    // Wait-type with arg=0 while Handshake=1: no wait
    instr_n = {7'b0100000, 5'b00000};
    hs      = 1'b1;
    step();
    step();
    check("nw_exec_stage", {30'd0, stage_n}, 32'd2);
    step();
    check("nw_wb_stage", {30'd0, stage_n}, 32'd3);
    check("nw_wb_pchold", {31'd0, pchold_n}, 32'd0);
    check("nw_wb_accwe", {31'd0, accwe_n}, 32'd0);
    step();

    // Reset in the middle of WAIT
    instr_n = {7'b0100000, 5'b00001};
    step();
    step();
    step();
    check("rw_in_wait_stage", {30'd0, stage_n}, 32'd2);
    check("rw_in_wait_pchold", {31'd0, pchold_n}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_all_zero", all_n(), 32'd0);
    step();
    reset = 1'b0;
    hs    = 1'b0;
    check("post_reset_fetch", {30'd0, stage_n}, 32'd0);
    step();
    check("post_reset_decode", {30'd0, stage_n}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
